// File: rtl/sum_bcd_display.sv
// Binary-to-BCD (double dabble) converter with scanned 7-segment output; done arrives IN_WIDTH+2 cycles after load.
// Loads are ignored while busy; the digit scan runs freely alongside conversions.
module sum_bcd_display #(
    parameter int IN_WIDTH    = 11,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_WIDTH-1:0] value,
    input  logic                load,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   an
);

    function automatic int bcd_digits(input int w);
        longint unsigned maxv;
        longint unsigned lim;
        int d;
        maxv = (64'd1 << w) - 64'd1;
        lim  = 64'd10;
        d    = 1;
        for (int i = 0; i < 19; i++) begin
            if (lim <= maxv) begin
                d   = d + 1;
                lim = lim * 64'd10;
            end
        end
        return d;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    localparam int CONV_DIGITS = bcd_digits(IN_WIDTH);
    localparam int NB          = (CONV_DIGITS > DIGITS) ? CONV_DIGITS : DIGITS;
    localparam int BW          = 4 * NB;
    localparam int BIT_W       = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam int CNT_W       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t                 state, state_nx;
    logic [IN_WIDTH-1:0]    bin;
    logic [BW-1:0]          bcd, bcd_adj;
    logic [4*DIGITS-1:0]    disp;
    logic [BIT_W-1:0]       bit_cnt;
    logic                   upd;
    logic                   high_nz;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NB; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    if (NB > DIGITS) begin : g_ovf
        assign high_nz = |bcd[BW-1:4*DIGITS];
    end else begin : g_no_ovf
        assign high_nz = 1'b0;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load) state_nx = SHIFT;
            SHIFT:   if (bit_cnt == '0) state_nx = LATCH;
            LATCH:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // done is delayed one cycle past the display-register write so it lines up with the registered seg output
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bin      <= '0;
            bcd      <= '0;
            bit_cnt  <= '0;
            disp     <= '0;
            overflow <= 1'b0;
            upd      <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_nx;
            upd   <= (state == LATCH);
            done  <= upd;
            case (state)
                IDLE: begin
                    if (load) begin
                        bin     <= value;
                        bcd     <= '0;
                        bit_cnt <= BIT_W'(IN_WIDTH - 1);
                    end
                end
                SHIFT: begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    bit_cnt    <= bit_cnt - 1'b1;
                end
                LATCH: begin
                    disp     <= bcd[4*DIGITS-1:0];
                    overflow <= high_nz;
                end
                default: ;
            endcase
        end
    end

    logic [CNT_W-1:0] scan_cnt;
    logic [IDX_W-1:0] idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    logic [3:0] cur;
    logic       cur_blank;
    logic       lz;
    logic [6:0] seg_nx;

    // lz tracks "this digit and everything above it is zero" while walking down from the MSD
    always_comb begin
        cur       = '0;
        cur_blank = 1'b0;
        lz        = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lz = lz & (disp[4*i +: 4] == 4'd0);
            if (idx == IDX_W'(i)) begin
                cur       = disp[4*i +: 4];
                cur_blank = lz && (i != 0);
            end
        end
        if (overflow)       seg_nx = 7'b0111111;
        else if (cur_blank) seg_nx = 7'b1111111;
        else                seg_nx = seg_of(cur);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= '1;
            seg <= 7'b1111111;
        end else begin
            an  <= ~(DIGITS'(1) << idx);
            seg <= seg_nx;
        end
    end

endmodule

// File: tb/tb_sum_bcd_display.sv
// Drives two configurations (12-bit/4-digit and 11-bit/3-digit) from shared stimulus,
// comparing every cycle against an arithmetic model of conversion timing and display.
module tb_sum_bcd_display;

    localparam int R = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [11:0] value;

    logic       busy_a, done_a, ovf_a;
    logic [6:0] seg_a;
    logic [3:0] an_a;
    logic       busy_b, done_b, ovf_b;
    logic [6:0] seg_b;
    logic [2:0] an_b;

    sum_bcd_display #(.IN_WIDTH(12), .DIGITS(4), .REFRESH_DIV(R)) dut_a (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .busy(busy_a), .done(done_a), .overflow(ovf_a), .seg(seg_a), .an(an_a)
    );

    sum_bcd_display #(.IN_WIDTH(11), .DIGITS(3), .REFRESH_DIV(R)) dut_b (
        .clk(clk), .rst(rst), .value(value[10:0]), .load(load),
        .busy(busy_b), .done(done_b), .overflow(ovf_b), .seg(seg_b), .an(an_b)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int W[2] = '{12, 11};
    int D[2] = '{4, 3};
    int g = 0;
    int k[2], g0[2], pend[2], shown[2];
    bit act[2], ovf_p[2], ovf_s[2], exp_done[2];

    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int val, input bit ov, input int di);
        int p;
        if (ov) return 7'b0111111;
        p = pow10(di);
        if (di != 0 && val < p) return 7'b1111111;
        return enc((val / p) % 10);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, g, obs, exp);
        end
    endtask

    task automatic model_edge(input int m);
        exp_done[m] = 1'b0;
        if (rst) begin
            k[m] = 0; act[m] = 0; ovf_p[m] = 0; ovf_s[m] = 0; shown[m] = 0;
        end else begin
            k[m]++;
            if (act[m]) begin
                if (g == g0[m] + W[m] + 1) ovf_p[m] = (pend[m] > pow10(D[m]) - 1);
                if (g == g0[m] + W[m] + 2) begin
                    exp_done[m] = 1'b1;
                    shown[m]    = pend[m];
                    ovf_s[m]    = ovf_p[m];
                    act[m]      = 1'b0;
                end
            end
            if (load && !act[m]) begin
                act[m]  = 1'b1;
                g0[m]   = g;
                pend[m] = int'(value) & ((1 << W[m]) - 1);
            end
        end
    endtask

    task automatic check_inst(input int m, input string nm, input logic b, input logic d,
                              input logic o, input logic [6:0] s, input logic [3:0] a);
        int di;
        logic [7:0] ea, es, mask;
        mask = 8'((1 << D[m]) - 1);
        if (k[m] == 0) begin
            ea = mask;
            es = 8'h7F;
        end else begin
            di = ((k[m] - 1) / R) % D[m];
            ea = ~(8'd1 << di) & mask;
            es = {1'b0, exp_seg(shown[m], ovf_s[m], di)};
        end
        chk({nm, ".busy"}, {7'b0, b}, {7'b0, act[m] && (g <= g0[m] + W[m])});
        chk({nm, ".done"}, {7'b0, d}, {7'b0, exp_done[m]});
        chk({nm, ".overflow"}, {7'b0, o}, {7'b0, ovf_p[m]});
        chk({nm, ".an"}, {4'b0, a}, ea);
        chk({nm, ".seg"}, {1'b0, s}, es);
    endtask

    task automatic tick();
        @(posedge clk);
        g++;
        model_edge(0);
        model_edge(1);
        #1;
        check_inst(0, "a", busy_a, done_a, ovf_a, seg_a, an_a);
        check_inst(1, "b", busy_b, done_b, ovf_b, seg_b, {1'b0, an_b});
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_load(input int v);
        value = 12'(v);
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; value = '0;
        run(3);
        rst = 1'b0;
        run(5);
        // 455, then the 11-bit maximum, then zero
        do_load(455);  run(30);
        do_load(2047); run(30);
        do_load(0);    run(30);
        // overflows only the 3-digit instance
        do_load(1500); run(30);
        // second load lands while busy and must be dropped
        do_load(3630); run(2);
        do_load(1234); run(30);
        // reset in the middle of a conversion, then redo it
        do_load(3750); run(5);
        rst = 1'b1; tick(); rst = 1'b0;
        run(6);
        do_load(3750); run(30);
        for (int i = 0; i < 30; i++) begin
            run($urandom_range(0, 18));
            do_load($urandom_range(0, 4095));
        end
        run(30);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sum_bcd_display.md
SUM_BCD_DISPLAY -- requirements
Module: sum_bcd_display

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 11, binary input width (adder sum width N+1 for N=10).
REQ-002 SHALL have parameter DIGITS, default 4, number of 7-segment digits.
REQ-003 SHALL have parameter REFRESH_DIV, default 50000, clock cycles each digit is driven before the scan advances.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 value  input  IN_WIDTH  unsigned binary sum to display.
REQ-008 load  input  1  capture value and start conversion when high in IDLE.
REQ-009 busy  output  1  high while a conversion is in progress.
REQ-010 done  output  1  one-cycle pulse when the displayed value is updated.
REQ-011 overflow  output  1  latched high when the last converted value exceeds 10^DIGITS-1.
REQ-012 seg  output  7  segments {g,f,e,d,c,b,a}; active-low.
REQ-013 an  output  DIGITS  digit enables; active-low, one-hot-low while scanning; bit 0 is the least significant digit.

Function
REQ-014 SHALL implement FSM IDLE -> SHIFT -> LATCH -> IDLE.
REQ-015 IDLE: when load=1, capture value into the shift register, clear the BCD register, and go to SHIFT; busy=1 from the next cycle.
REQ-016 SHIFT: each cycle, add 3 to every BCD nibble >=5, then shift {bcd,bin} left by 1; exactly IN_WIDTH cycles, then go to LATCH.
REQ-017 LATCH: copy the BCD result into the display register, set overflow if the BCD result needs more than DIGITS digits, pulse done for one cycle, set busy=0, return to IDLE.
REQ-018 Latency: load sampled at edge t gives done=1 and updated display data in cycle t+IN_WIDTH+2.
REQ-019 load while busy=1 SHALL be ignored; the conversion in progress is not disturbed.
REQ-020 The BCD register SHALL be wide enough for ceil(IN_WIDTH*log10(2)) digits; digits at or above DIGITS are used only for overflow detection.
REQ-021 Scan counter SHALL count 0..REFRESH_DIV-1 continuously; on wrap, the digit index advances modulo DIGITS (0,1,..,DIGITS-1,0).
REQ-022 an SHALL drive low only the bit equal to the digit index; seg SHALL show that digit's pattern; both outputs are registered.
REQ-023 Encoding (active-low {g..a}): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111, dash=0111111.
REQ-024 Leading-zero blanking: a digit SHALL be blank if it and all more-significant digits are 0, except digit 0, which always shows.
REQ-025 When overflow=1, every digit SHALL show dash.
REQ-026 Display scanning SHALL continue independently of the FSM; a display-register update takes effect on the next scanned digit without resetting the scan.

Reset
REQ-027 rst=1 SHALL return the FSM to IDLE and clear the scan counter, digit index, display register and overflow; a conversion in progress is abandoned.
REQ-028 During reset cycles, SHALL hold busy=0, done=0, an all 1s and seg=1111111.
REQ-029 In the first cycle after reset release, SHALL output an=...1110 and seg=1000000 (shows "0").

Verification
REQ-030 V1: defaults, REFRESH_DIV=4, load with value=455 -> done 13 cycles later; over a 16-cycle scan digit0 '5', digit1 '5', digit2 '4', digit3 blank.
REQ-031 V2: value=2047 (maximum) -> digits 7,4,0,2 on an bits 0..3; overflow=0.
REQ-032 V3: value=0 -> digit0 '0', digits 1-3 blank; done pulses exactly once, one cycle wide.
REQ-033 V4: DIGITS=3, value=1500 -> overflow=1 and all three digits show 0111111.
REQ-034 V5: load value=3630, then a second load with a different value 3 cycles later -> the second load is ignored and the display shows 3630.
REQ-035 V6: assert rst for 1 cycle midway through a conversion of 3750 -> busy=0, no done pulse, display shows "0"; a new load of 3750 afterwards completes normally.
